vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter_pkg.sv | 19 +
 rtl/vga_fb_arbiter_wr_fifo.sv | 74 +++++++
 rtl/vga_fb_arbiter.sv | 129 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and the ownership enum for the VGA frame-buffer arbiter.
package vga_fb_arbiter_pkg;

    localparam int unsigned H_RES     = 640;
    localparam int unsigned V_RES     = 480;
    localparam int unsigned FB_PIXELS = H_RES * V_RES;

    typedef enum logic [1:0] {
        DISP  = 2'd0,
        WRITE = 2'd1,
        IDLE  = 2'd2
    } owner_e;

    // True when a linear pixel address lies inside the visible frame.
    function automatic logic in_frame(input logic [31:0] addr);
        return addr < FB_PIXELS;
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_wr_fifo.sv
// Write buffer for the frame-buffer arbiter: synchronous FIFO with a registered ready flag.
module fb_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign do_push_c = push && ready_q;
    assign do_pop_c  = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Ready is held low throughout reset and derived from the next occupancy.
        ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign ready = ready_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display scan-out has priority, buffered writes fill blanking.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PIXEL_IN,
    input  logic [ADDR_W-1:0] P_COUNT_IN,
    input  logic              H_SYNC_IN,
    input  logic              V_SYNC_IN,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic              PIX_VALID,
    output logic              H_SYNC_OUT,
    output logic              V_SYNC_OUT,
    output logic              FRAME_START,
    output logic              WR_DROP
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    owner_e             state_c;
    logic               wr_fire_c;
    logic               in_range_c;
    logic               push_c;
    logic               pop_c;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    logic pix_valid_q,   pix_valid_d;
    logic h_sync_q,      h_sync_d;
    logic v_sync_q,      v_sync_d;
    logic frame_start_q, frame_start_d;
    logic wr_drop_q,     wr_drop_d;

    assign wr_fire_c  = WR_VALID && WR_READY;
    assign in_range_c = in_frame(32'(WR_ADDR));
    assign push_c     = wr_fire_c && in_range_c;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wr_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push_c),
        .wdata ({WR_ADDR, WR_DATA}),
        .pop   (pop_c),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .ready (WR_READY)
    );

    // Ownership is re-decided every cycle; reset forces IDLE so no partial write escapes.
    always_comb begin
        state_c = IDLE;
        if (!RST) begin
            state_c = IDLE;
        end else if (PIXEL_IN) begin
            state_c = DISP;
        end else if (!fifo_empty) begin
            state_c = WRITE;
        end
    end

    always_comb begin
        MEM_ADDR  = '0;
        MEM_WE    = 1'b0;
        MEM_WDATA = '0;
        pop_c     = 1'b0;
        case (state_c)
            DISP: begin
                MEM_ADDR = P_COUNT_IN;
            end
            WRITE: begin
                MEM_ADDR  = fifo_head[DATA_W +: ADDR_W];
                MEM_WDATA = fifo_head[DATA_W-1:0];
                MEM_WE    = 1'b1;
                pop_c     = 1'b1;
            end
            default: begin
                MEM_ADDR = '0;
            end
        endcase
    end

    always_comb begin
        pix_valid_d   = PIXEL_IN;
        h_sync_d      = H_SYNC_IN;
        v_sync_d      = V_SYNC_IN;
        frame_start_d = PIXEL_IN && (P_COUNT_IN == '0);
        wr_drop_d     = wr_fire_c && !in_range_c;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pix_valid_q   <= 1'b0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            frame_start_q <= 1'b0;
            wr_drop_q     <= 1'b0;
        end else begin
            pix_valid_q   <= pix_valid_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            frame_start_q <= frame_start_d;
            wr_drop_q     <= wr_drop_d;
        end
    end

    assign PIX_VALID   = pix_valid_q;
    assign PIX_DATA    = (RST && pix_valid_q) ? MEM_RDATA : '0;
    assign H_SYNC_OUT  = h_sync_q;
    assign V_SYNC_OUT  = v_sync_q;
    assign FRAME_START = frame_start_q;
    assign WR_DROP     = wr_drop_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed plus randomized bench for vga_fb_arbiter against a queue-based reference model.
module tb_vga_fb_arbiter;

    localparam int unsigned FB    = 307200;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        pixel_in;
    logic [18:0] p_count;
    logic        hs_in, vs_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        hs_out, vs_out;
    logic        frame_start;
    logic        wr_drop;

    int n_chk  = 0;
    int n_fail = 0;

    vga_fb_arbiter dut (
        .CLK         (clk),
        .RST         (rst),
        .PIXEL_IN    (pixel_in),
        .P_COUNT_IN  (p_count),
        .H_SYNC_IN   (hs_in),
        .V_SYNC_IN   (vs_in),
        .WR_VALID    (wr_valid),
        .WR_READY    (wr_ready),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .MEM_ADDR    (mem_addr),
        .MEM_WE      (mem_we),
        .MEM_WDATA   (mem_wdata),
        .MEM_RDATA   (mem_rdata),
        .PIX_DATA    (pix_data),
        .PIX_VALID   (pix_valid),
        .H_SYNC_OUT  (hs_out),
        .V_SYNC_OUT  (vs_out),
        .FRAME_START (frame_start),
        .WR_DROP     (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer model: unwritten locations read back their own address.
    bit [7:0] fb [FB];
    bit       fb_seen [FB];
    always @(posedge clk) begin
        if (mem_we && 32'(mem_addr) < FB) begin
            fb[mem_addr]      <= mem_wdata;
            fb_seen[mem_addr] <= 1'b1;
        end
        if (32'(mem_addr) < FB)
            mem_rdata <= fb_seen[mem_addr] ? fb[mem_addr] : 8'(mem_addr);
        else
            mem_rdata <= 8'h00;
    end

    // Reference model state
    wr_t         wq[$];
    logic [7:0]  ref_fb [FB];
    logic        rdy_m, pv_m, hs_m, vs_m, fs_m, drop_m;
    logic [18:0] pc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model at the falling edge.
    task automatic sample();
        logic        we_e;
        logic [18:0] a_e;
        logic [7:0]  d_e;
        logic [7:0]  px_e;
        @(negedge clk);
        we_e = rst && !pixel_in && (wq.size() != 0);
        a_e  = !rst ? 19'd0 : pixel_in ? p_count : we_e ? wq[0].a : 19'd0;
        d_e  = we_e ? wq[0].d : 8'd0;
        px_e = (rst && pv_m) ? ref_fb[pc_m] : 8'd0;
        chk("mem_we",      32'(mem_we),      32'(we_e));
        chk("mem_addr",    32'(mem_addr),    32'(a_e));
        if (!rst || !pixel_in)
            chk("mem_wdata", 32'(mem_wdata), 32'(d_e));
        chk("wr_ready",    32'(wr_ready),    32'(rdy_m));
        chk("pix_valid",   32'(pix_valid),   32'(pv_m));
        chk("pix_data",    32'(pix_data),    32'(px_e));
        chk("h_sync_out",  32'(hs_out),      32'(hs_m));
        chk("v_sync_out",  32'(vs_out),      32'(vs_m));
        chk("frame_start", 32'(frame_start), 32'(fs_m));
        chk("wr_drop",     32'(wr_drop),     32'(drop_m));
    endtask

    // Advance the model across the rising edge, then let inputs change.
    task automatic advance();
        logic fire;
        @(posedge clk);
        if (!rst) begin
            wq.delete();
            rdy_m  = 1'b0;
            pv_m   = 1'b0;
            hs_m   = 1'b1;
            vs_m   = 1'b1;
            fs_m   = 1'b0;
            drop_m = 1'b0;
        end else begin
            fire = wr_valid && rdy_m;
            if (!pixel_in && wq.size() != 0) begin
                ref_fb[wq[0].a] = wq[0].d;
                void'(wq.pop_front());
            end
            if (fire && 32'(wr_addr) < FB)
                wq.push_back(wr_t'{a: wr_addr, d: wr_data});
            drop_m = fire && (32'(wr_addr) >= FB);
            rdy_m  = (wq.size() != DEPTH);
            pv_m   = pixel_in;
            pc_m   = p_count;
            hs_m   = hs_in;
            vs_m   = vs_in;
            fs_m   = pixel_in && (p_count == 19'd0);
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    initial begin
        for (int i = 0; i < int'(FB); i++) ref_fb[i] = 8'(i);
        pc_m = '0;

        // Reset held three edges with a writer already requesting
        rst = 1'b0; pixel_in = 1'b1; p_count = '0; hs_in = 1'b0; vs_in = 1'b0;
        wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 8'h11;
        advance();
        repeat (2) begin
            sample();
            chk("rst_mem_we",   32'(mem_we),    0);
            chk("rst_wr_ready", 32'(wr_ready),  0);
            chk("rst_pix_val",  32'(pix_valid), 0);
            chk("rst_hsync",    32'(hs_out),    1);
            advance();
        end
        rst = 1'b1; wr_valid = 1'b0; pixel_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        cycle();
        sample();
        chk("ready_after_rst", 32'(wr_ready), 1);
        advance();

        // Blanking write goes straight to memory next cycle
        wr_valid = 1'b1; wr_addr = 19'd100; wr_data = 8'h5A;
        cycle();
        wr_valid = 1'b0;
        sample();
        chk("blank_we",   32'(mem_we),    1);
        chk("blank_addr", 32'(mem_addr),  100);
        chk("blank_data", 32'(mem_wdata), 32'h5A);
        advance();

        // Preemption: a whole active line with the writer pushing throughout
        pixel_in = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 640; i++) begin
            p_count = 19'(i); wr_addr = 19'(1000 + i); wr_data = 8'($urandom);
            sample();
            chk("pre_no_we", 32'(mem_we), 0);
            if (i >= 4) chk("pre_full", 32'(wr_ready), 0);
            advance();
        end
        pixel_in = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("drain_we",   32'(mem_we),   1);
            chk("drain_addr", 32'(mem_addr), 32'(1000 + i));
            advance();
        end
        sample();
        chk("drain_done", 32'(mem_we), 0);
        advance();

        // Scan-out of pixels 0..3 with frame start on the first
        pixel_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p_count = 19'(i);
            sample();
            if (i > 0) chk("scan_pix", 32'(pix_data), 32'(i - 1));
            if (i == 1) chk("frame_start_hi", 32'(frame_start), 1);
            if (i == 2) chk("frame_start_lo", 32'(frame_start), 0);
            advance();
        end
        pixel_in = 1'b0;
        sample();
        chk("scan_pix_last", 32'(pix_data), 3);
        advance();

        // Out-of-range write is dropped, last in-range address is written
        wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 8'h33;
        cycle();
        wr_valid = 1'b0;
        sample();
        chk("drop_pulse", 32'(wr_drop), 1);
        chk("drop_no_we", 32'(mem_we),  0);
        advance();
        sample();
        chk("drop_once", 32'(wr_drop), 0);
        chk("drop_ready", 32'(wr_ready), 1);
        advance();
        wr_valid = 1'b1; wr_addr = 19'd307199; wr_data = 8'hC3;
        cycle();
        wr_valid = 1'b0;
        sample();
        chk("edge_we",   32'(mem_we),   1);
        chk("edge_addr", 32'(mem_addr), 307199);
        advance();
        pixel_in = 1'b1; p_count = 19'd307199;
        cycle();
        pixel_in = 1'b0;
        sample();
        chk("edge_read", 32'(pix_data), 32'hC3);
        advance();

        // Two queued, then push and pop together across the pointer wrap
        pixel_in = 1'b1; p_count = 19'd10; wr_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_addr = 19'(2000 + i); wr_data = 8'($urandom);
            cycle();
        end
        pixel_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_addr = 19'(2002 + i); wr_data = 8'($urandom);
            sample();
            chk("sim_we",    32'(mem_we),   1);
            chk("sim_addr",  32'(mem_addr), 32'(2000 + i));
            chk("sim_ready", 32'(wr_ready), 1);
            advance();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("sim_tail", 32'(mem_addr), 32'(2006 + i));
            advance();
        end

        // Reset mid-operation discards buffered writes
        pixel_in = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = 19'(3000 + i); wr_data = 8'($urandom);
            cycle();
        end
        rst = 1'b0; pixel_in = 1'b0; wr_valid = 1'b0;
        sample();
        chk("midrst_no_we", 32'(mem_we), 0);
        advance();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("midrst_flushed", 32'(mem_we), 0);
            advance();
        end

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom % 300) != 0;
            pixel_in = ($urandom % 3) != 0;
            p_count  = ($urandom % 8 == 0) ? 19'd0 : 19'($urandom % FB);
            hs_in    = 1'($urandom);
            vs_in    = 1'($urandom);
            wr_valid = 1'($urandom);
            wr_addr  = ($urandom % 12 == 0) ? 19'(FB + ($urandom % (524288 - FB)))
                                            : 19'($urandom % FB);
            wr_data  = 8'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
